ds_cache_arbiter: RTL and testbench

DS_CACHE_ARBITER -- requirements
Module: ds_cache_arbiter

---
 rtl/ds_cache_arbiter.sv | 146 ++++++++++++++
 tb/tb_ds_cache_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ds_cache_arbiter.sv
// Round-robin arbiter placing one transaction at a time onto a downstream cache FSM,
// with a bounded wait for cache_ready and a one-cycle response pulse to the owner.
module ds_cache_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               cache_valid,
    output logic               cache_rw,
    output logic [31:0]        cache_addr,
    output logic [31:0]        cache_data,
    input  logic               cache_ready,
    input  logic [31:0]        cache_rdata,
    output logic               busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  last_q, last_d;
    logic [GW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rw_q, rw_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic [GW-1:0]  win;
    logic           found;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_vec;

    // Search starts one past the last served requester, so every requester gets a turn.
    always_comb begin
        logic [GW-1:0] cand;
        win   = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        grant      = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant[win] = 1'b1;
                    owner_d    = win;
                    rw_d       = req_rw[win];
                    addr_d     = req_addr[32*int'(win) +: 32];
                    data_d     = req_data[32*int'(win) +: 32];
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // cache_ready wins over a coincident timeout.
                if (cache_ready) begin
                    rsp_data_d = cache_rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= GW'(NREQ - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        rsp_vec          = '0;
        rsp_vec[owner_q] = (state_q == S_RESP);
    end

    // The accept pulse is decoded from live req_valid, so it is masked while reset is held.
    assign req_ready   = rst ? '0 : grant;
    assign rsp_valid   = rsp_vec;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign cache_valid = (state_q == S_WAIT);
    assign cache_rw    = rw_q;
    assign cache_addr  = addr_q;
    assign cache_data  = data_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ds_cache_arbiter.sv
// Self-checking bench for ds_cache_arbiter: directed scenarios plus a short random run,
// responses checked against an expected queue.
module tb_ds_cache_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int W       = 37;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               cache_valid;
    logic               cache_rw;
    logic [31:0]        cache_addr;
    logic [31:0]        cache_data;
    logic               cache_ready;
    logic [31:0]        cache_rdata;
    logic               busy;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    int checks = 0;
    int errors = 0;

    ds_cache_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cache_valid(cache_valid), .cache_rw(cache_rw), .cache_addr(cache_addr),
        .cache_data(cache_data), .cache_ready(cache_ready), .cache_rdata(cache_rdata),
        .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every response pulse must match the head of the queue
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(exp_e[36:33]));
                check("rsp_err", 64'(rsp_err), 64'(exp_e[32]));
                check("rsp_data", 64'(rsp_data), 64'(exp_e[31:0]));
            end
        end
    end

    // driver tasks
    task automatic set_req(input int id, input bit rw, input logic [31:0] addr,
                           input logic [31:0] data);
        req_valid[id]          = 1'b1;
        req_rw[id]             = rw;
        req_addr[32*id +: 32]  = addr;
        req_data[32*id +: 32]  = data;
    endtask

    // Called just after a falling edge; returns inside the accept cycle.
    task automatic wait_grant(input int id);
        bit got;
        logic [NREQ-1:0] exp_g;
        got   = 1'b0;
        exp_g = NREQ'(1) << id;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready != '0) got = 1'b1;
            else @(negedge clk);
        end
        check("grant", 64'(req_ready), 64'(exp_g));
    endtask

    // Called in the accept cycle; plays the cache side and ends in the following IDLE cycle.
    task automatic serve(input int id, input bit rw, input logic [31:0] addr,
                         input logic [31:0] data, input int delay,
                         input logic [31:0] rdata, input bit to, input bit drop);
        int n;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        exp_q.push_back({oh, to, to ? 32'h0 : rdata});
        @(negedge clk);
        if (drop) req_valid[id] = 1'b0;
        n = to ? TIMEOUT : delay;
        for (int i = 0; i < n; i++) begin
            check("wait_valid", 64'(cache_valid), 64'h1);
            check("wait_addr", 64'(cache_addr), 64'(addr));
            check("wait_data", 64'(cache_data), 64'(data));
            check("wait_rw", 64'(cache_rw), 64'(rw));
            req_addr[32*id +: 32] = $urandom;
            @(negedge clk);
        end
        if (!to) begin
            check("ready_addr", 64'(cache_addr), 64'(addr));
            check("ready_valid", 64'(cache_valid), 64'h1);
            cache_ready = 1'b1;
            cache_rdata = rdata;
            @(negedge clk);
            cache_ready = 1'b0;
            cache_rdata = $urandom;
        end
        #2;
        check("rsp_seen", 64'(exp_q.size()), 64'h0);
        check("resp_cache_valid", 64'(cache_valid), 64'h0);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'h0);
    endtask

    initial begin
        int id;
        int dly;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;

        rst         = 1'b1;
        req_valid   = '0;
        req_rw      = '0;
        req_addr    = '0;
        req_data    = '0;
        cache_ready = 1'b0;
        cache_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < NREQ; i++)
            set_req(i, i[0], 32'(100 + i), 32'(17 * i));
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", 64'({req_ready, rsp_valid, cache_valid, busy, rsp_err, cache_rw}), 64'h0);
        check("reset_rsp_data", 64'(rsp_data), 64'h0);
        check("reset_cache_addr", 64'(cache_addr), 64'h0);
        check("reset_cache_data", 64'(cache_data), 64'h0);

        // contention from reset: grant order 0,1,2,3,0
        @(negedge clk);
        rst = 1'b0;
        id  = 0;
        for (int t = 0; t < 5; t++) begin
            wait_grant(id);
            serve(id, req_rw[id], req_addr[32*id +: 32], req_data[32*id +: 32], 0, $urandom, 1'b0, 1'b0);
            id = (id + 1) % NREQ;
        end
        req_valid = '0;
        @(negedge clk);

        // single write request
        set_req(2, 1'b1, 32'd5, 32'h10);
        wait_grant(2);
        serve(2, 1'b1, 32'd5, 32'h10, 0, 32'h1234, 1'b0, 1'b1);

        // read data
        set_req(1, 1'b0, 32'h40, 32'h0);
        wait_grant(1);
        serve(1, 1'b0, 32'h40, 32'h0, 0, 32'h00AB, 1'b0, 1'b1);

        // address stability with a 5-cycle cache delay
        set_req(3, 1'b1, 32'h77, 32'h99);
        wait_grant(3);
        serve(3, 1'b1, 32'h77, 32'h99, 5, 32'h5555, 1'b0, 1'b1);

        // timeout, then a normal request
        set_req(0, 1'b0, 32'h200, 32'h0);
        wait_grant(0);
        serve(0, 1'b0, 32'h200, 32'h0, 0, 32'h0, 1'b1, 1'b1);
        set_req(1, 1'b1, 32'h300, 32'hABC);
        wait_grant(1);
        serve(1, 1'b1, 32'h300, 32'hABC, 1, 32'h0F0F, 1'b0, 1'b1);

        // cache_ready on the last allowed cycle beats the timeout
        set_req(2, 1'b0, 32'h400, 32'h0);
        wait_grant(2);
        serve(2, 1'b0, 32'h400, 32'h0, TIMEOUT - 1, 32'hCAFE, 1'b0, 1'b1);

        // reset in the middle of WAIT
        set_req(1, 1'b1, 32'h500, 32'h1);
        wait_grant(1);
        @(negedge clk);
        req_valid = '0;
        check("mid_wait_valid", 64'(cache_valid), 64'h1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'({req_ready, rsp_valid, cache_valid, busy, rsp_err}), 64'h0);
        check("mid_rst_addr", 64'(cache_addr), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(3, 1'b0, 32'h600, 32'h0);
        wait_grant(3);
        serve(3, 1'b0, 32'h600, 32'h0, 0, 32'h7777, 1'b0, 1'b1);

        // short random run with single requesters
        for (int t = 0; t < 8; t++) begin
            id  = $urandom_range(0, NREQ - 1);
            dly = $urandom_range(0, TIMEOUT - 2);
            a   = $urandom;
            d   = $urandom;
            r   = $urandom;
            set_req(id, t[0], a, d);
            wait_grant(id);
            serve(id, t[0], a, d, dly, r, 1'b0, 1'b1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
